// File: rtl/bsg_cache_nb_to_test_dram_wr_sched_pkg.sv
// Shared definitions for the cache-to-test-DRAM write scheduler slice.
//   wr_sched_state_e : scheduler FSM state encoding
//   safe_clog2       : log2 that never returns 0, so 1-entry widths stay legal
package bsg_cache_nb_to_test_dram_wr_sched_pkg;

  typedef enum logic {
    e_idle = 1'b0,
    e_send = 1'b1
  } wr_sched_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter.
// Grants the first requester at or after the pointer. The pointer moves to
// winner+1 (mod width_p) only when the grant is actually taken (yumi_i).
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset (pointer -> 0)
//   reqs_i         : request vector
//   grants_o       : one-hot grant (combinational from reqs_i and pointer)
//   v_o            : some request is being granted
//   tag_o          : index of the granted requester
//   yumi_i         : grant consumed this cycle; advance the pointer
module bsg_arb_round_robin
  import bsg_cache_nb_to_test_dram_wr_sched_pkg::*;
#(
  parameter  int width_p     = 4,
  localparam int lg_width_lp = safe_clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     reqs_i,
  output logic [width_p-1:0]     grants_o,
  output logic                   v_o,
  output logic [lg_width_lp-1:0] tag_o,
  input  logic                   yumi_i
);

  logic [lg_width_lp-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    grants_o = '0;
    v_o      = 1'b0;
    tag_o    = '0;
    idx      = 0;
    // Scan starting at the pointer, wrapping once; first hit wins.
    for (int i = 0; i < width_p; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= width_p) idx = idx - width_p;
      if (!v_o && reqs_i[lg_width_lp'(idx)]) begin
        v_o   = 1'b1;
        tag_o = lg_width_lp'(idx);
      end
    end
    if (v_o) grants_o[tag_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i && v_o) begin
      ptr_d = (int'(tag_o) == width_p - 1) ? '0 : tag_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_cache_nb_to_test_dram_wr_sched.sv
// Write-side scheduler in front of the non-blocking-cache to test-DRAM
// transmit datapath. Picks one cache's dirty block round-robin, then walks
// it beat by beat, issuing per beat one DRAM write command and one tag/mask
// entry to the transmit tag FIFO, in the same order on both streams.
//
// Handshakes:
//   dma_wr_v_i/dma_wr_yumi_o : yumi is asserted only in a cycle where the
//     matching valid is high; the block is taken in that cycle.
//   tx_v_o/tx_ready_i        : valid-then-ready; transfer when both high.
//     tx_v_o never depends on tx_ready_i.
//   dram_cmd_v_o/dram_cmd_yumi_i : consumer asserts yumi only while valid.
//
// Ports:
//   core_clk_i, core_reset_i : clock, synchronous active-high reset
//   dma_wr_v_i/addr_i/mask_i : per-cache block requests (flattened, cache i
//                              at slice i)
//   dma_wr_yumi_o            : one-hot request accept
//   tx_v_o/tag_o/mask_o      : tag FIFO entry (cache id, beat word mask)
//   tx_ready_i               : tag FIFO ready
//   dram_cmd_v_o/addr_o      : DRAM write command (beat byte address)
//   dram_cmd_yumi_i          : command consumed
//   busy_o                   : high while a block is being sent
module bsg_cache_nb_to_test_dram_wr_sched
  import bsg_cache_nb_to_test_dram_wr_sched_pkg::*;
#(
  parameter  int num_cache_p           = 4,
  parameter  int data_width_p          = 32,
  parameter  int block_size_in_words_p = 8,
  parameter  int dram_data_width_p     = 128,
  parameter  int addr_width_p          = 28,
  parameter  int skip_zero_mask_p      = 1,
  localparam int num_req_lp        = block_size_in_words_p*data_width_p/dram_data_width_p,
  localparam int words_per_beat_lp = block_size_in_words_p/num_req_lp,
  localparam int lg_num_cache_lp   = safe_clog2(num_cache_p)
) (
  input  logic                                      core_clk_i,
  input  logic                                      core_reset_i,
  input  logic [num_cache_p-1:0]                    dma_wr_v_i,
  input  logic [num_cache_p*addr_width_p-1:0]       dma_wr_addr_i,
  input  logic [num_cache_p*block_size_in_words_p-1:0] dma_wr_mask_i,
  output logic [num_cache_p-1:0]                    dma_wr_yumi_o,
  output logic                                      tx_v_o,
  output logic [lg_num_cache_lp-1:0]                tx_tag_o,
  output logic [words_per_beat_lp-1:0]              tx_mask_o,
  input  logic                                      tx_ready_i,
  output logic                                      dram_cmd_v_o,
  output logic [addr_width_p-1:0]                   dram_cmd_addr_o,
  input  logic                                      dram_cmd_yumi_i,
  output logic                                      busy_o
);

  localparam int lg_num_req_lp  = safe_clog2(num_req_lp);
  localparam int beat_bytes_lp  = dram_data_width_p / 8;
  localparam int block_bytes_lp = block_size_in_words_p * data_width_p / 8;
  localparam logic [addr_width_p-1:0] block_off_mask_lp = addr_width_p'(block_bytes_lp - 1);

  wr_sched_state_e state_q, state_d;
  logic [lg_num_req_lp-1:0]         k_q, k_d;
  logic                             cmd_sent_q, cmd_sent_d;
  logic                             tx_sent_q, tx_sent_d;
  logic [lg_num_cache_lp-1:0]       id_q, id_d;
  logic [addr_width_p-1:0]          base_q, base_d;
  logic [block_size_in_words_p-1:0] mask_q, mask_d;

  // Arbiter
  logic [num_cache_p-1:0]     arb_grants;
  logic                       arb_v;
  logic [lg_num_cache_lp-1:0] arb_tag;
  logic                       grant_accept;

  // Accept is valid -> yumi only; downstream ready plays no part. Reset
  // gates it so no cache is yumied while the block is being reset.
  assign grant_accept = (state_q == e_idle) && arb_v && !core_reset_i;

  bsg_arb_round_robin #(
    .width_p(num_cache_p)
  ) arb (
    .clk_i   (core_clk_i),
    .reset_i (core_reset_i),
    .reqs_i  (dma_wr_v_i),
    .grants_o(arb_grants),
    .v_o     (arb_v),
    .tag_o   (arb_tag),
    .yumi_i  (grant_accept)
  );

  logic [addr_width_p-1:0]          req_addr;
  logic [block_size_in_words_p-1:0] req_mask;
  assign req_addr = dma_wr_addr_i[int'(arb_tag)*addr_width_p +: addr_width_p];
  assign req_mask = dma_wr_mask_i[int'(arb_tag)*block_size_in_words_p +: block_size_in_words_p];

  // Per-beat datapath
  logic                         run;
  logic [words_per_beat_lp-1:0] beat_mask;
  logic [addr_width_p-1:0]      beat_addr;
  logic                         skip;
  logic                         cmd_v, tx_v;
  logic                         cmd_done, tx_done, beat_done, last_beat;

  // Everything downstream is silenced during reset, even in the reset
  // cycle where state_q may still read SEND.
  assign run       = (state_q == e_send) && !core_reset_i;
  assign beat_mask = mask_q[int'(k_q)*words_per_beat_lp +: words_per_beat_lp];
  assign beat_addr = base_q + addr_width_p'(int'(k_q) * beat_bytes_lp);
  assign skip      = (skip_zero_mask_p != 0) && (beat_mask == '0);
  assign last_beat = (int'(k_q) == num_req_lp - 1);

  // Each stream holds its valid until its own handshake, then stays quiet
  // until the other stream catches up; the beat retires when both are done.
  assign cmd_v     = run && !skip && !cmd_sent_q;
  assign tx_v      = run && !skip && !tx_sent_q;
  assign cmd_done  = cmd_sent_q || (cmd_v && dram_cmd_yumi_i);
  assign tx_done   = tx_sent_q  || (tx_v && tx_ready_i);
  assign beat_done = run && (skip || (cmd_done && tx_done));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cmd_sent_d = cmd_sent_q;
    tx_sent_d  = tx_sent_q;
    id_d       = id_q;
    base_d     = base_q;
    mask_d     = mask_q;
    case (state_q)
      e_idle: begin
        if (grant_accept) begin
          state_d    = e_send;
          k_d        = '0;
          cmd_sent_d = 1'b0;
          tx_sent_d  = 1'b0;
          id_d       = arb_tag;
          base_d     = req_addr & ~block_off_mask_lp;
          mask_d     = req_mask;
        end
      end
      e_send: begin
        if (beat_done) begin
          cmd_sent_d = 1'b0;
          tx_sent_d  = 1'b0;
          if (last_beat) begin
            state_d = e_idle;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          cmd_sent_d = cmd_done;
          tx_sent_d  = tx_done;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      state_q    <= e_idle;
      k_q        <= '0;
      cmd_sent_q <= 1'b0;
      tx_sent_q  <= 1'b0;
      id_q       <= '0;
      base_q     <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cmd_sent_q <= cmd_sent_d;
      tx_sent_q  <= tx_sent_d;
      id_q       <= id_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
    end
  end

  assign dma_wr_yumi_o   = grant_accept ? arb_grants : '0;
  assign dram_cmd_v_o    = cmd_v;
  assign dram_cmd_addr_o = run ? beat_addr : '0;
  assign tx_v_o          = tx_v;
  assign tx_tag_o        = run ? id_q : '0;
  assign tx_mask_o       = run ? beat_mask : '0;
  assign busy_o          = run;

endmodule
